// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned.
// Divide-by-zero skips the iterations and reports all-ones quotient.
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  prem;
    logic [N-1:0]  pquo;
    logic [N-1:0]  dvs;
    logic          q_neg;
    logic          r_neg;
    logic          dbz;

    logic [N-1:0]  shifted;
    logic [N:0]    trial;
    logic [N-1:0]  abs_dvd;
    logic [N-1:0]  abs_dvs;

    // prem never exceeds the dividend bits shifted in so far, so its MSB
    // is always clear before a shift and an N-bit register suffices.
    always_comb begin
        shifted = {prem[N-2:0], pquo[N-1]};
        trial   = {1'b0, shifted} + {1'b1, ~dvs} + {{N{1'b0}}, 1'b1};
        abs_dvd = (is_signed && dividend[N-1]) ? -dividend : dividend;
        abs_dvs = (is_signed && divisor[N-1])  ? -divisor  : divisor;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            prem        <= '0;
            pquo        <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            pquo  <= dividend;
                            dbz   <= 1'b1;
                            state <= FIN;
                        end else begin
                            prem  <= '0;
                            pquo  <= abs_dvd;
                            dvs   <= abs_dvs;
                            q_neg <= is_signed & (dividend[N-1] ^ divisor[N-1]);
                            r_neg <= is_signed & dividend[N-1];
                            dbz   <= 1'b0;
                            count <= CW'(N);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[N]) begin
                        prem <= trial[N-1:0];
                        pquo <= {pquo[N-2:0], 1'b1};
                    end else begin
                        prem <= shifted;
                        pquo <= {pquo[N-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIN;
                end
                FIN: begin
                    done <= 1'b1;
                    if (dbz) begin
                        quotient    <= '1;
                        remainder   <= pquo;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? -pquo : pquo;
                        remainder   <= r_neg ? -prem : prem;
                        div_by_zero <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic model.
// Latency is counted in falling edges after start is first driven.
module tb_seq_divider;

    localparam int N = 16;
    localparam int BOUND = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int vectors;
    int miscompares;

    seq_divider #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    input logic s, output logic [15:0] q,
                                    output logic [15:0] r, output logic z);
        int sa;
        int sb;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Drives one request, scrambles inputs after acceptance, waits for done.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input logic s, output int lat, output logic bsy1);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        lat       = 1;
        bsy1      = busy;
        start     = 1'b0;
        dividend  = 16'($urandom);
        divisor   = 16'($urandom);
        is_signed = 1'($urandom);
        while (!done && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [15:0] a,
                                input logic [15:0] b, input logic s,
                                input int lat, input logic bsy1);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          elat;
        ref_div(a, b, s, eq, er, ez);
        elat = ez ? 2 : N + 2;
        vectors++;
        if (lat !== elat) begin
            miscompares++;
            $display("FAIL %s latency a=%h b=%h s=%0d got %0d want %0d",
                     name, a, b, s, lat, elat);
        end
        vectors++;
        if ({bsy1, quotient, remainder, div_by_zero} !== {1'b1, eq, er, ez}) begin
            miscompares++;
            $display("FAIL %s result a=%h b=%h s=%0d got busy=%0d q=%h r=%h z=%0d want busy=1 q=%h r=%h z=%0d",
                     name, a, b, s, bsy1, quotient, remainder, div_by_zero, eq, er, ez);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%0d done=%0d q=%h r=%h z=%0d want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [8];
        logic [15:0] tb [8];
        logic        ts [8];
        int          lat;
        logic        b1;
        ta = '{16'd100, 16'hFFF9, 16'd7, 16'd1234, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF};
        tb = '{16'd7, 16'h0002, 16'hFFFE, 16'd0, 16'h8001, 16'hFFFF, 16'h0001, 16'hFFFF};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            do_div(ta[i], tb[i], ts[i], lat, b1);
            check_result("directed", ta[i], tb[i], ts[i], lat, b1);
        end
        @(negedge clk);
        vectors++;
        if ({done, quotient, remainder} !== {1'b0, 16'd1, 16'd0}) begin
            miscompares++;
            $display("FAIL done_pulse_hold got done=%0d q=%h r=%h want done=0 q=0001 r=0000",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        int          lat;
        logic        b1;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 5));
                2: b = 16'hFFFF;
                3: a = 16'h8000;
                default: ;
            endcase
            do_div(a, b, s, lat, b1);
            check_result("random", a, b, s, lat, b1);
        end
    endtask

    task automatic test_busy_ignore();
        int   lat;
        logic b1;
        @(negedge clk);
        dividend  = 16'd50;
        divisor   = 16'd5;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        lat   = 1;
        b1    = busy;
        start = 1'b0;
        while (!done && lat < BOUND) begin
            if (lat == 5) begin
                dividend = 16'd9;
                divisor  = 16'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_result("busy_ignore", 16'd50, 16'd5, 1'b0, lat, b1);
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic b1;
        do_div(16'd9, 16'd3, 1'b0, lat, b1);
        check_result("back_to_back", 16'd9, 16'd3, 1'b0, lat, b1);
    endtask

    task automatic test_reset_mid();
        int   seen;
        int   lat;
        logic b1;
        @(negedge clk);
        dividend  = 16'd1000;
        divisor   = 16'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%0d done=%0d q=%h r=%h z=%0d want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy)
                seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_abort got %0d active cycles want 0", seen);
        end
        do_div(16'd1000, 16'd3, 1'b0, lat, b1);
        check_result("after_reset", 16'd1000, 16'd3, 1'b0, lat, b1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative N-bit integer divider, one quotient bit per clock (restoring shift-subtract).
- Inverse counterpart to the datapath adders; the subtract path is an (N+1)-bit add of the one's-complement divisor plus carry-in 1.
- Sits beside the ALU as a multi-cycle execute unit; the pipeline control stalls on busy and consumes results on done.

Parameters:
N, 16, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a divide; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with start
dividend  input  N  numerator; latched with start
divisor  input  N  denominator; latched with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid that cycle and held afterwards
quotient  output  N  registered quotient
remainder  output  N  registered remainder
div_by_zero  output  1  registered; set with done when the latched divisor was 0

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset (any time, including mid-operation): state=IDLE; busy, done, div_by_zero, quotient and remainder all 0. The operation in flight is aborted and no done is issued.
- States: IDLE, CALC, FIN.
- IDLE, start=1, divisor!=0:
  - Latch the operands.
  - If is_signed, store |dividend| and |divisor|, plus sign flags q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clear the partial remainder, set count=N, go to CALC.
- IDLE, start=1, divisor==0: go directly to FIN with the dbz flag set.
- CALC, each cycle:
  - {prem, pquo} shifted left 1; the MSB of pquo enters the LSB of prem.
  - trial = {0, prem} - {0, divisor}, computed at (N+1) bits.
  - If trial[N]==0: prem = trial[N-1:0] and pquo[0] = 1. Otherwise prem is kept and pquo[0] = 0.
  - count decrements; after the N-th iteration go to FIN.
- FIN, one cycle:
  - done=1.
  - quotient = q_neg ? -pquo : pquo.
  - remainder = r_neg ? -prem : prem.
  - div_by_zero=0.
  - Next state IDLE.
- FIN with dbz:
  - quotient = all ones.
  - remainder = latched dividend, unmodified.
  - div_by_zero=1.
- Latency: start accepted at edge t gives done high in the cycle after edge t+N+1 (N+1 cycles of busy before done, counting FIN). The divide-by-zero path gives done in the cycle after edge t+1.
- start while busy (CALC or FIN) is ignored; a new start is accepted the cycle after done.
- Input changes after acceptance have no effect.
- quotient, remainder and div_by_zero hold their values until the next FIN.
- Signed results truncate toward zero. The remainder carries the dividend's sign, and |remainder| < |divisor|.
- Signed overflow (-2^(N-1) / -1): quotient = -2^(N-1) (two's-complement wrap), remainder=0, div_by_zero=0.
- Absolute value of -2^(N-1) is handled as the unsigned value 2^(N-1); no special case is needed in CALC.
- The subtractor must be N+1 bits wide; an N-bit compare fails for a divisor with MSB set in unsigned mode.

Test Plan:
- Unsigned 100/7, start at cycle 0 -> busy for 17 cycles, done pulse at cycle 17, quotient=14, remainder=2, div_by_zero=0.
- Signed -7/2 (0xFFF9/0x0002) -> quotient=0xFFFD (-3), remainder=0xFFFF (-1). Signed 7/-2 -> quotient=0xFFFD, remainder=0x0001.
- Divide by zero, unsigned 1234/0 -> done at cycle 2, quotient=0xFFFF, remainder=1234 (0x04D2), div_by_zero=1.
- Edge values, unsigned 0xFFFF/0x8001 -> quotient=1, remainder=0x7FFE. Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
- Start 50/5 at cycle 0, pulse start with 9/3 at cycle 5 -> second request ignored, done at 17 with quotient=10, remainder=0. Start 9/3 at cycle 18 -> done at 35 with quotient=3, remainder=0.
- Reset mid-operation: start 1000/3, assert rst_n=0 at cycle 8 -> busy, done and all outputs 0 immediately; no done after release; a following 1000/3 yields quotient=333, remainder=1.
